// File: rtl/mem_stage_waited.sv
// mem_stage_waited
//   MEM pipeline stage with a private word-addressed data memory and an
//   emulated access latency. A load or store is held by the upstream stage
//   until ready_out rises. The stage then spends WAIT_CYCLES cycles in BUSY,
//   commits the access, and reports completion for one cycle in DONE.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   mem_read_in   load request, held until ready_out=1
//   mem_write_in  store request, held until ready_out=1 (wins over a load)
//   address_in    byte address; BASE_ADDR maps to word 0, low 2 bits ignored
//   data_in       store data
//   data_out      registered load result, held until the next load completes
//   ready_out     0 = freeze upstream, 1 = stage may advance
//   state_dbg     current FSM state (0=IDLE, 1=BUSY, 2=DONE)
//
// Handshake: a request (mem_read_in | mem_write_in) is presented and held
// with stable address/data/type while ready_out=0. The cycle in which
// ready_out=1 with the request still high is the completion cycle. The
// upstream stage advances there and must drop or change the request before
// the next edge. Dropping the request while the stage is BUSY aborts the
// access: memory is not written and data_out is left unchanged.
module mem_stage_waited #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready_out,
  output logic [1:0]        state_dbg
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              req;
  logic              commit;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  index;
  logic              unused_offset_bits;

  logic [DATA_W-1:0] mem [DEPTH];

  assign req = mem_read_in | mem_write_in;

  // Word index relative to BASE_ADDR. Taking only IDX_W bits above the
  // byte lane gives the modulo-DEPTH wrap for free.
  assign offset             = address_in - ADDR_W'(BASE_ADDR);
  assign index              = offset[IDX_W+1:2];
  assign unused_offset_bits = ^{offset[ADDR_W-1:IDX_W+2], offset[1:0]};

  assign ready_out = ~req | (state == DONE);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        if (!req) begin
          // Upstream withdrew the request: abandon it without side effects.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // A store takes priority, so a simultaneous load leaves data_out alone.
      if (commit && !mem_write_in && mem_read_in) begin
        data_out <= mem[index];
      end
    end
  end

  // Memory contents survive reset. An asynchronous reset forces the state
  // to IDLE, so commit cannot fire while reset is held.
  always_ff @(posedge clk) begin
    if (commit && mem_write_in) begin
      mem[index] <= data_in;
    end
  end

endmodule

// File: tb/tb_mem_stage_waited.sv
// tb_mem_stage_waited
//   Directed bench for mem_stage_waited with default parameters
//   (DATA_W=32, ADDR_W=32, DEPTH=64, BASE_ADDR=1024, WAIT_CYCLES=4).
//   Inputs change on the falling edge. Outputs are sampled 1 time unit
//   after the falling edge, well away from the rising (active) edge.
module tb_mem_stage_waited;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic              clk;
  logic              rst;
  logic              mem_read_in;
  logic              mem_write_in;
  logic [ADDR_W-1:0] address_in;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              ready_out;
  logic [1:0]        state_dbg;

  int total;
  int bad;

  mem_stage_waited #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .BASE_ADDR(1024), .WAIT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in),
    .address_in(address_in),
    .data_in(data_in),
    .data_out(data_out),
    .ready_out(ready_out),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a request and holds it until ready_out rises (bounded).
  // Returns the number of stalled cycles, whether completion was seen,
  // and data_out/state as observed in the completion cycle. The request
  // is dropped inside the completion cycle, as an advancing pipeline would.
  task automatic do_access(input logic wr, input logic rd,
                           input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata,
                           output int stalls, output logic done,
                           output logic [DATA_W-1:0] dout,
                           output logic [1:0] st);
    @(negedge clk);
    mem_write_in = wr;
    mem_read_in  = rd;
    address_in   = addr;
    data_in      = wdata;
    stalls = 0;
    done   = 1'b0;
    dout   = '0;
    st     = 2'd3;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ready_out) begin
        done = 1'b1;
        dout = data_out;
        st   = state_dbg;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    mem_write_in = 1'b0;
    mem_read_in  = 1'b0;
  endtask

  int                stalls;
  logic              done;
  logic [DATA_W-1:0] dout;
  logic [1:0]        st;

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    address_in   = '0;
    data_in      = '0;

    // 1. reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_data_out", 64'(data_out), 64'h0);
    check("rst_ready", 64'(ready_out), 64'h1);
    check("rst_state", 64'(state_dbg), 64'(S_IDLE));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("idle_ready", 64'(ready_out), 64'h1);
    check("idle_state", 64'(state_dbg), 64'(S_IDLE));

    // 2. store 0xDEADBEEF @1024: 5 stalled cycles then one DONE cycle
    do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, stalls, done, dout, st);
    check("st0_stalls", 64'(stalls), 64'd5);
    check("st0_done", 64'(done), 64'h1);
    check("st0_done_state", 64'(st), 64'(S_DONE));
    check("st0_data_out_kept", 64'(dout), 64'h0);
    @(negedge clk);
    #1;
    check("st0_back_idle", 64'(state_dbg), 64'(S_IDLE));

    // 3. load @1024 returns the stored word and holds it while idle
    do_access(1'b0, 1'b1, 32'd1024, 32'h0, stalls, done, dout, st);
    check("ld0_stalls", 64'(stalls), 64'd5);
    check("ld0_done", 64'(done), 64'h1);
    check("ld0_data", 64'(dout), 64'hDEADBEEF);
    repeat (3) @(negedge clk);
    #1;
    check("ld0_data_held", 64'(data_out), 64'hDEADBEEF);
    check("ld0_idle_ready", 64'(ready_out), 64'h1);

    // 4. address wrap: 1024 + 4*DEPTH maps to word 0; low bits ignored
    do_access(1'b1, 1'b0, 32'd1024 + 32'(4 * DEPTH), 32'h11, stalls, done, dout, st);
    check("wrap_st_done", 64'(done), 64'h1);
    do_access(1'b0, 1'b1, 32'd1024, 32'h0, stalls, done, dout, st);
    check("wrap_ld_1024", 64'(dout), 64'h11);
    do_access(1'b1, 1'b0, 32'd1028, 32'hCAFE0001, stalls, done, dout, st);
    do_access(1'b0, 1'b1, 32'd1028, 32'h0, stalls, done, dout, st);
    check("ld_1028", 64'(dout), 64'hCAFE0001);
    do_access(1'b0, 1'b1, 32'd1026, 32'h0, stalls, done, dout, st);
    check("wrap_ld_1026", 64'(dout), 64'h11);

    // write priority: both requests high acts as a store, data_out kept
    do_access(1'b1, 1'b1, 32'd1032, 32'h77, stalls, done, dout, st);
    check("prio_stalls", 64'(stalls), 64'd5);
    check("prio_data_out_kept", 64'(dout), 64'h11);
    do_access(1'b0, 1'b1, 32'd1032, 32'h0, stalls, done, dout, st);
    check("prio_ld_1032", 64'(dout), 64'h77);

    // seed word 1 so an aborted store has something to disturb
    do_access(1'b1, 1'b0, 32'd1028, 32'hA5A5, stalls, done, dout, st);

    // 5. store 0x55 @1028 dropped after two BUSY cycles
    @(negedge clk);
    mem_write_in = 1'b1;
    address_in   = 32'd1028;
    data_in      = 32'h55;
    @(negedge clk);
    #1;
    check("abort_busy", 64'(state_dbg), 64'(S_BUSY));
    @(negedge clk);
    mem_write_in = 1'b0;
    #1;
    check("abort_ready", 64'(ready_out), 64'h1);
    @(negedge clk);
    #1;
    check("abort_idle", 64'(state_dbg), 64'(S_IDLE));
    do_access(1'b0, 1'b1, 32'd1028, 32'h0, stalls, done, dout, st);
    check("abort_mem1_kept", 64'(dout), 64'hA5A5);

    // 6. reset during a BUSY load
    @(negedge clk);
    mem_read_in = 1'b1;
    address_in  = 32'd1024;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_mid_busy", 64'(state_dbg), 64'(S_BUSY));
    rst = 1'b0;
    #1;
    check("rst_mid_data_out", 64'(data_out), 64'h0);
    check("rst_mid_state", 64'(state_dbg), 64'(S_IDLE));
    mem_read_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_access(1'b0, 1'b1, 32'd1024, 32'h0, stalls, done, dout, st);
    check("rst_reload_done", 64'(done), 64'h1);
    check("rst_reload_data", 64'(dout), 64'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
